// File: rtl/fp_sdiv_pkg.sv
// Shared types and helpers for the signed fixed-point multiply-by-reciprocal divider.
// Define FP_SDIV_ROUND_EN to round the quotient half-up instead of truncating it.
package fp_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the full unsigned product of the two magnitudes.
  function automatic int prod_width(input int wi, input int wf, input int wir, input int wfr);
    return wi + wf + wir + wfr;
  endfunction

endpackage

// File: rtl/fp_sat_trunc.sv
// Reduces the unsigned product magnitude to the quotient format, saturates and restores sign.
// FP_SDIV_ROUND_EN selects half-up rounding at the first dropped bit instead of truncation.
module fp_sat_trunc #(
  parameter int WP  = 32,
  parameter int FP  = 16,
  parameter int WQ  = 16,
  parameter int WFQ = 8
) (
  input  logic [WP-1:0] mag_i,
  input  logic          sign_i,
  output logic [WQ-1:0] dout_o,
  output logic          ovf_o
);

  // One spare bit so a rounding carry or a left shift never wraps.
  localparam int MW = WP + WQ + 1;

  logic [MW-1:0] mag_ext;
  logic [MW-1:0] scaled;
  logic [MW-1:0] lim_neg;
  logic [MW-1:0] lim_pos;
  logic [WQ-1:0] mag_q;

  assign mag_ext = MW'(mag_i);

  generate
    if (WFQ >= FP) begin : g_extend
      assign scaled = mag_ext << (WFQ - FP);
    end else begin : g_reduce
`ifdef FP_SDIV_ROUND_EN
      assign scaled = (mag_ext >> (FP - WFQ)) + MW'(mag_i[FP-WFQ-1]);
`else
      assign scaled = mag_ext >> (FP - WFQ);
`endif
    end
  endgenerate

  always_comb begin
    lim_neg = MW'(1) << (WQ - 1);
    lim_pos = lim_neg - 1'b1;
    mag_q   = scaled[WQ-1:0];
    ovf_o   = sign_i ? (scaled > lim_neg) : (scaled > lim_pos);
    if (ovf_o) begin
      dout_o = sign_i ? {1'b1, {(WQ-1){1'b0}}} : {1'b0, {(WQ-1){1'b1}}};
    end else begin
      // Negating a zero magnitude yields zero, so -0 never appears.
      dout_o = sign_i ? (~mag_q + 1'b1) : mag_q;
    end
  end

endmodule

// File: rtl/fp_sdiv_mul.sv
// Signed fixed-point quotient as dividend times reciprocal, via serial radix-2 shift-add.
// Handshake: a transfer happens on a CE-enabled rising edge where valid and ready are both high;
// in_ready is (state==IDLE)&&CE, out_valid holds with stable dout/ovf until taken by out_ready.
// FP_SDIV_ROUND_EN selects half-up rounding of the quotient (same latency either way).
module fp_sdiv_mul
  import fp_sdiv_pkg::*;
#(
  parameter int WI  = 8,
  parameter int WF  = 8,
  parameter int WIR = 8,
  parameter int WFR = 8,
  parameter int WIQ = WI,
  parameter int WFQ = WF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WI+WF-1:0]   din_a,
  input  logic [WIR+WFR-1:0] din_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIQ+WFQ-1:0] dout,
  output logic               ovf,
  output state_t             dbg_state
);

  localparam int WA = WI + WF;
  localparam int WR = WIR + WFR;
  localparam int WP = prod_width(WI, WF, WIR, WFR);
  localparam int WQ = WIQ + WFQ;
  localparam int CW = $clog2(WR + 1);

  state_t          state_q, state_d;
  logic [WP-1:0]   a_sh_q, a_sh_d;
  logic [WR-1:0]   r_sh_q, r_sh_d;
  logic [WP-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            valid_q, valid_d;
  logic [WQ-1:0]   dout_q, dout_d;
  logic            ovf_q, ovf_d;

  logic [WA-1:0]   a_abs;
  logic [WR-1:0]   r_abs;
  logic [WQ-1:0]   sat_dout;
  logic            sat_ovf;

  // Most negative input maps to 2^(W-1) as an unsigned magnitude.
  assign a_abs = din_a[WA-1] ? (~din_a + 1'b1) : din_a;
  assign r_abs = din_r[WR-1] ? (~din_r + 1'b1) : din_r;

  assign in_ready  = (state_q == IDLE) && CE;
  assign out_valid = valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

  fp_sat_trunc #(
    .WP (WP),
    .FP (WF + WFR),
    .WQ (WQ),
    .WFQ(WFQ)
  ) u_sat (
    .mag_i (acc_q),
    .sign_i(sign_q),
    .dout_o(sat_dout),
    .ovf_o (sat_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      r_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      r_sh_q  <= r_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (CE) begin
      case (state_q)
        IDLE:    if (in_valid) state_d = MUL;
        MUL:     if (cnt_q == CW'(WR - 1)) state_d = DONE;
        DONE:    if (valid_q && out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    r_sh_d  = r_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_d = WP'(a_abs);
            r_sh_d = r_abs;
            sign_d = din_a[WA-1] ^ din_r[WR-1];
            acc_d  = '0;
            cnt_d  = '0;
          end
        end
        MUL: begin
          if (r_sh_q[0]) acc_d = acc_q + a_sh_q;
          a_sh_d = a_sh_q << 1;
          r_sh_d = r_sh_q >> 1;
          cnt_d  = cnt_q + 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the result; it then holds until taken.
          if (!valid_q) begin
            valid_d = 1'b1;
            dout_d  = sat_dout;
            ovf_d   = sat_ovf;
          end else if (out_ready) begin
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sdiv_mul.sv
// Directed bench for fp_sdiv_mul at default Q8.8 parameters: vector table plus
// hand-written backpressure, reset-abort and clock-enable stall sequences.
module tb_fp_sdiv_mul;
  import fp_sdiv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] din_a = '0;
  logic [15:0] din_r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] dout;
  logic        ovf;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  fp_sdiv_mul dut (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (CE),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din_a    (din_a),
    .din_r    (din_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] r;
    logic [15:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic accept_pair(input logic [15:0] a, input logic [15:0] r);
    int t = 0;
    @(negedge CLK);
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      din_a = a;
      din_r = r;
      in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge CLK);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [15:0] rnd0, rnd1;

    vecs[0]  = '{16'h0300, 16'h0080, 16'h0180, 1'b0};
    vecs[1]  = '{16'hFD00, 16'h0080, 16'hFE80, 1'b0};
    vecs[2]  = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1};
    vecs[3]  = '{16'h6400, 16'h0400, 16'h7FFF, 1'b1};
    vecs[4]  = '{16'h6400, 16'hFC00, 16'h8000, 1'b1};
    vecs[6]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0};
    vecs[7]  = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};
    vecs[8]  = '{16'hFE80, 16'hFE00, 16'h0300, 1'b0};
    vecs[9]  = '{16'h0000, 16'hFF00, 16'h0000, 1'b0};
    vecs[11] = '{16'h0101, 16'h0101, 16'h0102, 1'b0};
    vecs[12] = '{16'h0040, 16'h0040, 16'h0010, 1'b0};
`ifdef FP_SDIV_ROUND_EN
    vecs[5]  = '{16'h0001, 16'h0080, 16'h0001, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h0080, 16'hFFFF, 1'b0};
`else
    vecs[5]  = '{16'h0001, 16'h0080, 16'h0000, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0};
`endif

    // Clock/reset: hold reset with CE low so in_ready must read 0.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    CE = 1'b1;
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      accept_pair(vecs[i].a, vecs[i].r);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_o));
      release_out();
    end

    // Backpressure: result held for 5 cycles, then a back-to-back new pair.
    accept_pair(16'h0300, 16'h0080);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      check("bp_dout", 32'(dout), 32'h0180);
      check("bp_ovf", 32'(ovf), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    release_out();
    check("bp_released_valid", 32'(out_valid), 32'd0);
    check("bp_released_state", 32'(dbg_state), 32'(IDLE));
    check("bp_released_ready", 32'(in_ready), 32'd1);
    din_a = 16'h0200;
    din_r = 16'h0200;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    check("bp_next_accept", 32'(dbg_state), 32'(MUL));
    wait_valid(lat);
    check("bp_next_latency", 32'(lat), 32'd17);
    check("bp_next_dout", 32'(dout), 32'h0400);
    release_out();

    // Reset in the middle of MUL discards the operation.
    accept_pair(16'h0300, 16'h0080);
    repeat (7) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge CLK);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // CE low for 3 edges mid-MUL stretches latency by exactly 3.
    accept_pair(16'h0180, 16'h0100);
    lat = 0;
    while (lat < 100) begin
      @(posedge CLK);
      lat++;
      #1;
      if (lat == 5) CE = 1'b0;
      if (lat == 6) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (lat == 8) CE = 1'b1;
      if (out_valid) break;
    end
    check("stall_latency", 32'(lat), 32'd20);
    check("stall_dout", 32'(dout), 32'h0180);
    release_out();

    // Two extra random-magnitude small operands, expected computed from integer math.
    rnd0 = 16'($urandom_range(0, 255));
    rnd1 = 16'($urandom_range(0, 255));
    accept_pair(rnd0, rnd1);
    wait_valid(lat);
    check("rnd_dout", 32'(dout), 32'((32'(rnd0) * 32'(rnd1)) >> 8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sdiv_mul.md
FP_SDIV_MUL -- requirements
Module: fp_sdiv_mul

Interface
REQ-001 The module SHALL expose parameter WI, default 8, meaning dividend integer bits, sign included.
REQ-002 The module SHALL expose parameter WF, default 8, meaning dividend fractional bits.
REQ-003 The module SHALL expose parameter WIR, default 8, meaning reciprocal integer bits; it equals the upstream reciprocal stage's WIO.
REQ-004 The module SHALL expose parameter WFR, default 8, meaning reciprocal fractional bits; it equals the upstream reciprocal stage's WFO.
REQ-005 The module SHALL expose parameter WIQ, default WI, meaning quotient integer bits.
REQ-006 The module SHALL expose parameter WFQ, default WF, meaning quotient fractional bits.
REQ-007 The module SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-008 The module SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-009 The module SHALL have port CE, input, 1 bit: clock enable; when low, all state is frozen.
REQ-010 The module SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-011 The module SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-012 The module SHALL have port din_a, input, WI+WF bits: signed two's-complement dividend.
REQ-013 The module SHALL have port din_r, input, WIR+WFR bits: signed reciprocal of the divisor, taken from the upstream reciprocal stage's dout.
REQ-014 The module SHALL have port out_valid, output, 1 bit: the quotient is present.
REQ-015 The module SHALL have port out_ready, input, 1 bit: downstream accepts the quotient.
REQ-016 The module SHALL have port dout, output, WIQ+WFQ bits: signed quotient equal to din_a times din_r.
REQ-017 The module SHALL have port ovf, output, 1 bit: dout was saturated; valid while out_valid is high.

Function
REQ-018 The FSM SHALL have states IDLE, MUL and DONE; in_ready SHALL equal (state==IDLE) AND CE.
REQ-019 On a CE-enabled edge with in_valid and in_ready high, the block SHALL do three things:
- latch the magnitudes |din_a| and |din_r| as unsigned values of WI+WF and WIR+WFR bits (the most negative input maps to 2^(W-1));
- latch sign = din_a[MSB] XOR din_r[MSB];
- clear the accumulator, clear the iteration counter and enter MUL.
REQ-020 MUL SHALL perform radix-2 shift-add, one reciprocal-magnitude bit per CE-enabled cycle, LSB first, into an unsigned accumulator of WI+WF+WIR+WFR bits.
REQ-021 MUL SHALL last exactly WIR+WFR CE-enabled cycles, then go to DONE; out_valid SHALL rise WIR+WFR+1 CE-enabled edges after the accept edge.
REQ-022 The product binary point SHALL sit WF+WFR bits from the LSB.
REQ-023 Quotient magnitude SHALL take WFQ fractional bits by truncation; if WFQ > WF+WFR, it SHALL be zero-extended.
REQ-024 Saturation: if the magnitude exceeds 2^(WIQ+WFQ-1)-1 for a positive sign, or 2^(WIQ+WFQ-1) for a negative sign, then dout SHALL be 0111..1 or 1000..0 respectively, with ovf=1; otherwise ovf=0.
REQ-025 Otherwise dout SHALL be the magnitude when sign=0, and its two's complement when sign=1; a zero magnitude SHALL yield 0 regardless of sign.
REQ-026 In DONE, dout, ovf and out_valid SHALL stay stable until a CE-enabled edge with out_ready=1, after which the FSM SHALL return to IDLE.
REQ-027 There is no accept/produce overlap: a new pair is accepted no earlier than the edge after the DONE handshake.
REQ-028 With CE low, FSM state, counter, accumulator and outputs SHALL hold; in_ready SHALL be 0.

Reset
REQ-029 While RST=1 at a rising edge, the FSM SHALL go to IDLE regardless of CE and the accumulator and counter SHALL clear; in_ready, out_valid, ovf and dout SHALL then be 0, and any operation in flight SHALL be discarded without producing a result.

Configuration
REQ-030 Macro FP_SDIV_ROUND_EN SHALL select the fractional reduction:
- defined: magnitude is rounded half-up at bit position WF+WFR-WFQ-1 before the saturation check, and a carry out of rounding can cause saturation;
- undefined: magnitude is truncated per REQ-023.
Latency SHALL be identical in both builds.

Structure
REQ-031 Package fp_sdiv_pkg SHALL hold the FSM state typedef (IDLE/MUL/DONE) and a constant function returning the product width.
REQ-032 Saturation, rounding and sign restoration SHALL live in one combinational sub-module, fp_sat_trunc, instantiated once.

Verification
All scenarios use defaults (Q8.8, 16-cycle MUL).
REQ-033 din_a=0x0300 (3.0), din_r=0x0080 (0.5) -> dout=0x0180, ovf=0, out_valid 17 edges after accept.
REQ-034 din_a=0xFD00 (-3.0), din_r=0x0080 -> dout=0xFE80; din_a=0x8000, din_r=0xFF00 (-1.0) -> dout=0x7FFF, ovf=1.
REQ-035 din_a=0x6400 (100.0), din_r=0x0400 (4.0) -> dout=0x7FFF, ovf=1; din_r=0xFC00 -> dout=0x8000, ovf=1.
REQ-036 out_ready held low 5 cycles after out_valid -> dout and ovf stable, in_ready=0; release -> IDLE on the next edge, new pair accepted on the following edge.
REQ-037 RST pulsed in cycle 8 of MUL -> out_valid never asserts for that pair, all outputs 0; CE low for 3 cycles mid-MUL -> latency extends by exactly 3.
REQ-038 din_a=0x0001, din_r=0x0080 -> dout=0x0000 without FP_SDIV_ROUND_EN, and 0x0001 with it.
